bit_stream_packer: RTL and testbench

- Sits directly downstream of the packet parser.
- Consumes the serial image bit stream (one bit per strobe) that the parser emits after header and command decode.
- Packs bits MSB-first into DATA_WIDTH-bit words and buffers them in a small FIFO.
- Presents the words on a valid/ready interface to the JPEG entropy-decoding front end.

---
 rtl/bit_stream_packer.sv | 121 ++++++++++++
 tb/tb_bit_stream_packer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bit_stream_packer.sv
// Packs a serial bit stream MSB-first into DATA_WIDTH-bit words and queues them in a FIFO for a valid/ready consumer.
// Optional JPEG byte destuffing (drop 00 after FF) is enabled by defining PACKER_DESTUFF_EN.
module bit_stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          input_bit,
  input  logic                          is_new_input_bit,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];

  logic [DATA_WIDTH-1:0] shift_a, padded, push_word;
  logic [CNT_W-1:0]      cnt_a;
  logic [CNT_W:0]        pad_n;
  logic                  word_done, pad_push, push_req, suppress;
  logic                  full, pop, push_ok;

`ifdef PACKER_DESTUFF_EN
  logic prev_ff_q, prev_ff_d;
`endif

  // Packing: the strobed bit is absorbed before any flush padding is considered.
  always_comb begin
    shift_a   = shift_q;
    cnt_a     = cnt_q;
    word_done = 1'b0;
    if (is_new_input_bit) begin
      shift_a   = {shift_q[DATA_WIDTH-2:0], input_bit};
      word_done = (cnt_q == CNT_W'(DATA_WIDTH - 1));
      cnt_a     = word_done ? '0 : cnt_q + CNT_W'(1);
    end
    pad_push  = flush && !word_done && (cnt_a != '0);
    pad_n     = (CNT_W+1)'(DATA_WIDTH) - {1'b0, cnt_a};
    padded    = (shift_a << pad_n) | ~({DATA_WIDTH{1'b1}} << pad_n);
    push_req  = word_done || pad_push;
    push_word = word_done ? shift_a : padded;
    shift_d   = shift_a;
    cnt_d     = pad_push ? '0 : cnt_a;
  end

`ifdef PACKER_DESTUFF_EN
  // The FF history tracks every completed word, including ones later dropped on overflow.
  always_comb begin
    suppress  = 1'b0;
    prev_ff_d = prev_ff_q;
    if (push_req) begin
      if (prev_ff_q && (push_word == '0)) begin
        suppress  = 1'b1;
        prev_ff_d = 1'b0;
      end else begin
        prev_ff_d = (push_word == {DATA_WIDTH{1'b1}});
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  always_comb begin
    full       = (level_q == (PTR_W+1)'(FIFO_DEPTH));
    pop        = (level_q != '0) && out_ready;
    push_ok    = push_req && !suppress && (!full || pop);
    overflow_d = overflow_q || (push_req && !suppress && full && !pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d    = level_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
    mem_d      = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      mem_q      <= '{default: '0};
    end else begin
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

`ifdef PACKER_DESTUFF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_ff_q <= 1'b0;
    else      prev_ff_q <= prev_ff_d;
  end
`endif

  assign out_data   = mem_q[rd_ptr_q];
  assign out_valid  = (level_q != '0);
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_bit_stream_packer.sv
// Directed bench for bit_stream_packer: packing, latency, flush padding, full/overflow, async reset, destuffing.
module tb_bit_stream_packer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       input_bit = 1'b0;
  logic       is_new_input_bit = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic [4:0] fifo_level;
  logic       overflow;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  bit_stream_packer #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .input_bit(input_bit), .is_new_input_bit(is_new_input_bit),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    input_bit = b;
    is_new_input_bit = 1'b1;
    step();
    is_new_input_bit = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    step();
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_dat"}, 32'(out_data), 32'(e));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    chk({tag, "_empty"}, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    #2;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_lvl", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    step();

    // Streaming with the consumer always ready
    out_ready = 1'b1;
    w = 8'hBA;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    chk("t1_pre_vld", 32'(out_valid), 32'd0);
    send_bit(w[0]);
    chk("t1_w0_vld", 32'(out_valid), 32'd1);
    chk("t1_w0_dat", 32'(out_data), 32'hBA);
    send_bit(1'b1);
    chk("t1_gap_vld", 32'(out_valid), 32'd0);
    w = 8'hCD;
    for (int i = 6; i >= 0; i--) send_bit(w[i]);
    chk("t1_w1_vld", 32'(out_valid), 32'd1);
    chk("t1_w1_dat", 32'(out_data), 32'hCD);
    step();
    chk("t1_lvl", 32'(fifo_level), 32'd0);
    out_ready = 1'b0;

    // Overflow: 17 words into a 16-entry FIFO
    for (int i = 0; i < 17; i++) send_word(8'(8'h10 + i));
    chk("t2_lvl", 32'(fifo_level), 32'd16);
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
    drain("t2");
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);

    // Flush padding
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    chk("t3_nopush", 32'(fifo_level), 32'd0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t3_pad_lvl", 32'(fifo_level), 32'd1);
    exp_q.push_back(8'h9F);
    drain("t3_pad");
    flush = 1'b1; step(); flush = 1'b0;
    chk("t3_idle_flush", 32'(fifo_level), 32'd0);
    w = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    flush = 1'b1; send_bit(w[0]); flush = 1'b0;
    step();
    chk("t3_coinc_full_lvl", 32'(fifo_level), 32'd1);
    exp_q.push_back(8'h3C);
    drain("t3_coinc_full");
    send_bit(1'b1); send_bit(1'b1);
    flush = 1'b1; send_bit(1'b0); flush = 1'b0;
    chk("t3_coinc_part_lvl", 32'(fifo_level), 32'd1);
    exp_q.push_back(8'hDF);
    drain("t3_coinc_part");

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) send_word(8'(8'h40 + i));
    chk("t4_full_lvl", 32'(fifo_level), 32'd16);
    w = 8'hA5;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    out_ready = 1'b1;
    send_bit(w[0]);
    out_ready = 1'b0;
    chk("t4_lvl", 32'(fifo_level), 32'd16);
    chk("t4_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
    exp_q.push_back(8'hA5);
    drain("t4");

    // Asynchronous reset mid-word with queued data
    send_word(8'h11); send_word(8'h22); send_word(8'h33);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    chk("t5_pre_lvl", 32'(fifo_level), 32'd3);
    rst = 1'b0;
    #2;
    chk("t5_rst_vld", 32'(out_valid), 32'd0);
    chk("t5_rst_lvl", 32'(fifo_level), 32'd0);
    rst = 1'b1;
    step();
    send_word(8'h55);
    chk("t5_lvl", 32'(fifo_level), 32'd1);
    exp_q.push_back(8'h55);
    drain("t5");

    // Byte destuffing
    send_word(8'hFF); send_word(8'h00); send_word(8'h12);
    exp_q.push_back(8'hFF);
`ifndef PACKER_DESTUFF_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'h12);
    chk("t6_lvl", 32'(fifo_level), 32'(exp_q.size()));
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
